knapsack_dp_ctrl: RTL and testbench
===================================

// Module: knapsack_dp_ctrl
// PURPOSE
//  Sequencer for the 0/1-knapsack dynamic-programming datapath. Holds a writable item table
//  (weight/value) and a DP cache array. On start it clears the cache, sweeps every item over
//  the capacity range one cell per cycle, then presents cache[cap] as the result.
//  Sits between the config/UART loader and the 7-segment display path.
// PARAMETERS
//  MAX_CAP   64  number of DP cache cells, indices 0..MAX_CAP-1
//  MAX_ITEM  16  item table depth
//  DW        8   weight/value/cache data width
//  AW        6   cache index width, clog2(MAX_CAP)
//  IW        4   item index width, clog2(MAX_ITEM)
// PORTS
//  CLK_10      in   1     system clock for this block
//  reset       in   1     synchronous, active-high reset
//  cfg_we      in   1     item table write strobe; ignored while busy
//  cfg_addr    in   IW    item index written
//  cfg_weight  in   DW    item weight
//  cfg_value   in   DW    item value
//  item_num    in   IW+1  items to process; sampled at start; clamped to MAX_ITEM
//  cap         in   AW    knapsack capacity; sampled at start
//  start       in   1     one-cycle request; honoured only when busy=0
//  busy        out  1     high from cycle after accepted start through DONE cycle
//  done        out  1     one-cycle pulse in DONE state
//  result      out  DW    cache[cap] latched in DONE; held until next DONE or reset
//  ovf         out  1     sticky saturation flag for current run; cleared on start
//  cur_item    out  IW    item index being swept (debug)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0, ovf=0, cur_item=0; item table and cache cleared.
//  Reset mid-run aborts immediately. No partial result is kept.
//  FSM: IDLE -> CLEAR -> LOAD -> SWEEP -> LOAD ... -> DONE -> IDLE.
//  IDLE: on start, latch cap and min(item_num, MAX_ITEM); clear ovf; idx=0; go to CLEAR.
//  CLEAR: cache[idx]=0 for idx=0..cap, one cell/cycle (cap+1 cycles).
//    Then LOAD if items>0, else DONE.
//  LOAD (1 cycle): latch w=weight[cur_item] and v=value[cur_item].
//    If w<=cap: idx=cap, go to SWEEP. Else skip the item: go to next LOAD, or DONE after last item.
//  SWEEP: per cycle, cache[idx] <= max(cache[idx], sat(cache[idx-w]+v)).
//    Descending idx gives 0/1 semantics; the read sees pre-write values.
//    Ends at idx==w (cap-w+1 cycles). Then cur_item++ -> LOAD, or DONE after last item.
//  w==0: sweep cap+1 cells (idx cap..0); each cell gains v exactly once.
//  Arithmetic: DW+1-bit add; if sum>2^DW-1 use 2^DW-1 and set ovf. Compare unsigned.
//  DONE (1 cycle): result<=cache[cap]; done=1; busy=1; next state IDLE.
//  Busy cycles = (cap+1) + sum_i[1 + (w_i<=cap ? cap-w_i+1 : 0)] + 1.
//  start while busy: ignored, no queueing. cfg_we while busy: ignored.
//  start and cfg_we in same IDLE cycle: write completes; run uses the new entry.
//  cap>=MAX_CAP cannot occur (AW bits). cap=0: only w=0 items contribute.
// TESTING
//  1. cap=5, items (w,v)=(2,12),(1,10),(3,20),(2,15),(1,8); start
//     -> busy exactly 33 cycles, done pulse, result=38, ovf=0.
//  2. cap=3, one item (5,50) -> item skipped; busy 6 cycles; result=0.
//  3. cap=2, items (1,200),(1,100) -> result=255, ovf=1; rerun with (1,20),(1,30) -> result=50, ovf=0.
//  4. item_num=0, cap=7 -> busy 9 cycles; result=0; done pulses once.
//  5. Mid-sweep start and cfg_we to addr0 -> both ignored; result matches the unperturbed run.
//  6. reset asserted during SWEEP of test 1 -> next cycle busy=0, result=0, ovf=0;
//     table reads zero (rerun gives result=0).

Source files
------------

// File: rtl/knapsack_dp_ctrl.sv
// knapsack_dp_ctrl
//   Sequencer for the 0/1-knapsack dynamic-programming datapath. It holds a
//   writable item table (weight/value) and a DP cache array. When started, it
//   clears cache[0..cap], then sweeps each item over the capacity range at one
//   cell per cycle, and finally presents cache[cap] as the result.
//
// Ports
//   CLK_10      in   system clock
//   reset       in   synchronous, active-high reset
//   cfg_we      in   item table write strobe (ignored while busy)
//   cfg_addr    in   item index to write
//   cfg_weight  in   item weight
//   cfg_value   in   item value
//   item_num    in   number of items to process, sampled at start, clamped to MAX_ITEM
//   cap         in   knapsack capacity, sampled at start
//   start       in   one-cycle run request (ignored while busy)
//   busy        out  high from the cycle after an accepted start through the DONE cycle
//   done        out  one-cycle pulse in the DONE state
//   result      out  cache[cap], captured in DONE and held until the next DONE
//   ovf         out  sticky saturation flag for the current run
//   cur_item    out  index of the item being swept (debug)
module knapsack_dp_ctrl #(
  parameter int MAX_CAP  = 64,
  parameter int MAX_ITEM = 16,
  parameter int DW       = 8,
  parameter int AW       = 6,
  parameter int IW       = 4
) (
  input  logic          CLK_10,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_weight,
  input  logic [DW-1:0] cfg_value,
  input  logic [IW:0]   item_num,
  input  logic [AW-1:0] cap,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          ovf,
  output logic [IW-1:0] cur_item
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_SWEEP,
    S_DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] item_w [MAX_ITEM];
  logic [DW-1:0] item_v [MAX_ITEM];
  logic [DW-1:0] cache  [MAX_CAP];
  logic [AW-1:0] cap_r;
  logic [IW:0]   items_r;
  logic [AW-1:0] idx;
  logic [DW-1:0] w_r;
  logic [DW-1:0] v_r;

  logic [DW-1:0] rd_w;
  logic [DW-1:0] rd_v;
  logic          fits;
  logic          last_item;
  logic [AW-1:0] src_idx;
  logic [DW:0]   sum;
  logic [DW-1:0] sat;
  logic [DW-1:0] best;
  logic [IW:0]   items_clamped;

  always_comb begin
    rd_w      = item_w[cur_item];
    rd_v      = item_v[cur_item];
    fits      = rd_w <= DW'(cap_r);
    last_item = ({1'b0, cur_item} + (IW+1)'(1)) == items_r;
    // In SWEEP, w_r <= cap_r, so the low AW bits hold the whole weight and
    // idx - w never wraps.
    src_idx   = idx - w_r[AW-1:0];
    sum       = {1'b0, cache[src_idx]} + {1'b0, v_r};
    sat       = sum[DW] ? '1 : sum[DW-1:0];
    best      = (sat > cache[idx]) ? sat : cache[idx];
    items_clamped = (item_num > (IW+1)'(MAX_ITEM)) ? (IW+1)'(MAX_ITEM) : item_num;
  end

  always_ff @(posedge CLK_10) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
      cur_item <= '0;
      cap_r    <= '0;
      items_r  <= '0;
      idx      <= '0;
      w_r      <= '0;
      v_r      <= '0;
      for (int unsigned i = 0; i < MAX_ITEM; i++) begin
        item_w[i] <= '0;
        item_v[i] <= '0;
      end
      for (int unsigned i = 0; i < MAX_CAP; i++) begin
        cache[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_we) begin
            item_w[cfg_addr] <= cfg_weight;
            item_v[cfg_addr] <= cfg_value;
          end
          if (start) begin
            cap_r    <= cap;
            items_r  <= items_clamped;
            ovf      <= 1'b0;
            idx      <= '0;
            cur_item <= '0;
            busy     <= 1'b1;
            state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          cache[idx] <= '0;
          if (idx == cap_r) begin
            if (items_r == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_LOAD;
            end
          end else begin
            idx <= idx + AW'(1);
          end
        end
        S_LOAD: begin
          w_r <= rd_w;
          v_r <= rd_v;
          if (fits) begin
            idx   <= cap_r;
            state <= S_SWEEP;
          end else if (last_item) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cur_item <= cur_item + IW'(1);
          end
        end
        S_SWEEP: begin
          // The sweep runs with descending idx, so cache[src_idx] still holds
          // its value from the previous item and each item is used once.
          cache[idx] <= best;
          if (sum[DW]) ovf <= 1'b1;
          if (DW'(idx) == w_r) begin
            if (last_item) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              cur_item <= cur_item + IW'(1);
              state    <= S_LOAD;
            end
          end else begin
            idx <= idx - AW'(1);
          end
        end
        S_DONE: begin
          result <= cache[cap_r];
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knapsack_dp_ctrl.sv
module tb_knapsack_dp_ctrl;

  logic       CLK_10 = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_weight;
  logic [7:0] cfg_value;
  logic [4:0] item_num;
  logic [5:0] cap;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       ovf;
  logic [3:0] cur_item;

  knapsack_dp_ctrl #(.MAX_CAP(64), .MAX_ITEM(16), .DW(8), .AW(6), .IW(4)) dut (
    .CLK_10    (CLK_10),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_weight(cfg_weight),
    .cfg_value (cfg_value),
    .item_num  (item_num),
    .cap       (cap),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf),
    .cur_item  (cur_item)
  );

  always #5 CLK_10 = ~CLK_10;

  typedef struct {
    logic [7:0] res;
    logic       ov;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   tw [16];
  int   tv [16];

  task automatic tick();
    @(posedge CLK_10);
    #1;
  endtask

  task automatic write_item(input int a, input int w, input int v);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_weight = 8'(w); cfg_value = 8'(v);
    tick();
    cfg_we = 1'b0;
    tw[a] = w; tv[a] = v;
  endtask

  // Reference DP: descending 0/1 sweep with saturation, plus cycle count.
  function automatic exp_t model(input int c, input int n);
    exp_t e;
    int dp [64];
    int s;
    int nn;
    nn = (n > 16) ? 16 : n;
    for (int j = 0; j < 64; j++) dp[j] = 0;
    e.ov = 1'b0;
    e.cyc = c + 2;
    for (int i = 0; i < nn; i++) begin
      e.cyc += 1;
      if (tw[i] <= c) begin
        e.cyc += c - tw[i] + 1;
        for (int j = c; j >= tw[i]; j--) begin
          s = dp[j - tw[i]] + tv[i];
          if (s > 255) begin s = 255; e.ov = 1'b1; end
          if (s > dp[j]) dp[j] = s;
        end
      end
    end
    e.res = 8'(dp[c]);
    return e;
  endfunction

  task automatic push_exp(input int r, input bit o, input int cy);
    exp_t e;
    e.res = 8'(r); e.ov = o; e.cyc = cy;
    sb.push_back(e);
  endtask

  // Starts a run, counts busy cycles and done pulses, then compares against
  // the oldest scoreboard entry. perturb_at>0 drives start+cfg_we mid-run.
  task automatic run(input int c, input int n, input int perturb_at);
    exp_t e;
    int cyc = 0;
    int dones = 0;
    bit timeout = 1'b0;
    cap = 6'(c); item_num = 5'(n); start = 1'b1;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    while (busy === 1'b1 && !timeout) begin
      cyc++;
      if (done === 1'b1) dones++;
      if (perturb_at > 0 && cyc == perturb_at) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_weight = 8'd1; cfg_value = 8'd99;
      end
      tick();
      start = 1'b0; cfg_we = 1'b0;
      if (cyc > 3000) timeout = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if (timeout) $display("FAIL run_timeout busy stuck after %0d cycles", cyc);
    else if (cyc !== e.cyc) $display("FAIL busy_cycles got %0d expected %0d", cyc, e.cyc);
    else passed++;
    checks++;
    if (dones !== 1) $display("FAIL done_pulses got %0d expected 1", dones); else passed++;
    checks++;
    if (result !== e.res) $display("FAIL result got %0d expected %0d", result, e.res); else passed++;
    checks++;
    if (ovf !== e.ov) $display("FAIL ovf got %0b expected %0b", ovf, e.ov); else passed++;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0 || ovf !== 1'b0 || cur_item !== 4'd0)
      $display("FAIL %s busy=%b done=%b result=%0d ovf=%b cur_item=%0d expected all zero",
               tag, busy, done, result, ovf, cur_item);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_weight = '0; cfg_value = '0;
    item_num = '0; cap = '0; start = 1'b0;
    for (int i = 0; i < 16; i++) begin tw[i] = 0; tv[i] = 0; end
    tick(); tick();
    reset = 1'b0;
    tick();
    check_idle_outputs("reset_state");
  endtask

  task automatic load_test1_items();
    write_item(0, 2, 12); write_item(1, 1, 10); write_item(2, 3, 20);
    write_item(3, 2, 15); write_item(4, 1, 8);
  endtask

  task automatic test_basic();
    load_test1_items();
    push_exp(38, 1'b0, 33);
    run(5, 5, 0);
  endtask

  task automatic test_skip();
    // Write lands in the same IDLE cycle as start; the run must see it.
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_weight = 8'd5; cfg_value = 8'd50;
    tw[0] = 5; tv[0] = 50;
    push_exp(0, 1'b0, 6);
    run(3, 1, 0);
  endtask

  task automatic test_saturation();
    write_item(0, 1, 200); write_item(1, 1, 100);
    push_exp(255, 1'b1, 10);
    run(2, 2, 0);
    write_item(0, 1, 20); write_item(1, 1, 30);
    push_exp(50, 1'b0, 10);
    run(2, 2, 0);
    tick(); tick();
    checks++;
    if (result !== 8'd50) $display("FAIL result_hold got %0d expected 50", result); else passed++;
  endtask

  task automatic test_no_items();
    push_exp(0, 1'b0, 9);
    run(7, 0, 0);
  endtask

  task automatic test_ignore_busy();
    load_test1_items();
    sb.push_back(model(5, 5));
    run(5, 5, 15);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy !== 1'b0) $display("FAIL start_queued busy=%b expected 0", busy); else passed++;
      tick();
    end
    // Entry 0 must be unchanged by the ignored write.
    sb.push_back(model(5, 1));
    run(5, 1, 0);
  endtask

  task automatic test_back_to_back();
    int c, n;
    for (int i = 0; i < 8; i++) write_item(i, $urandom_range(0, 8), $urandom_range(0, 120));
    for (int r = 0; r < 3; r++) begin
      c = $urandom_range(0, 63);
      n = (r == 2) ? 20 : $urandom_range(1, 8);
      if (r == 2) for (int i = 8; i < 16; i++) write_item(i, $urandom_range(0, 63), $urandom_range(0, 255));
      sb.push_back(model(c, n));
      run(c, n, 0);
    end
  endtask

  task automatic test_reset_mid_run();
    load_test1_items();
    push_exp(38, 1'b0, 33);
    run(5, 5, 0);
    cap = 6'd5; item_num = 5'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    checks++;
    if (busy !== 1'b1 || cur_item === 4'd0) $display("FAIL pre_reset_sweep busy=%b cur_item=%0d expected busy=1 cur_item>0", busy, cur_item);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("reset_mid_run");
    for (int i = 0; i < 16; i++) begin tw[i] = 0; tv[i] = 0; end
    push_exp(0, 1'b0, 42);
    run(5, 5, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_saturation();
    test_no_items();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
